// File: rtl/mx_result_deserializer.sv
// Receive-side collector for the bit-serial MAC array: per-lane serial
// word assembly, per-lane FIFOs and a round-robin valid/ready output port.
module mx_result_deserializer #(
   parameter int NUM_LANES  = 4,
   parameter int ACC_WIDTH  = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_LANES-1:0]         result_i,
   input  logic [NUM_LANES-1:0]         mac_en_i,
   input  logic [NUM_LANES-1:0]         lane_abort_i,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_WIDTH-1:0]         out_data,
   output logic [$clog2(NUM_LANES)-1:0] out_lane,
   output logic [NUM_LANES-1:0]         overflow,
   input  logic                         clear_overflow
);
   localparam int LW  = $clog2(NUM_LANES);
   localparam int CW  = $clog2(ACC_WIDTH);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int PCW = PW + 1;
   localparam logic [CW-1:0]  LAST_BIT  = CW'(ACC_WIDTH - 1);
   localparam logic [PCW-1:0] FULL_CNT  = PCW'(FIFO_DEPTH);
   localparam logic [LW-1:0]  LAST_LANE = LW'(NUM_LANES - 1);

   logic [ACC_WIDTH-1:0] sr    [NUM_LANES];
   logic [CW-1:0]        cnt   [NUM_LANES];
   logic [ACC_WIDTH-1:0] mem   [NUM_LANES][FIFO_DEPTH];
   logic [PW-1:0]        wp    [NUM_LANES];
   logic [PW-1:0]        rp    [NUM_LANES];
   logic [PCW-1:0]       count [NUM_LANES];
   logic [ACC_WIDTH-1:0] word  [NUM_LANES];

   logic [NUM_LANES-1:0] filled;
   logic [NUM_LANES-1:0] done;
   logic [NUM_LANES-1:0] pop;
   logic [NUM_LANES-1:0] accept;
   logic [NUM_LANES-1:0] drop;

   logic [LW-1:0] rr;
   logic [LW-1:0] grant;
   logic [LW-1:0] held_lane;
   logic          held;
   logic          handshake;
   logic          found;
   int            idx;

   // sr is zero above cnt, so the completing bit can simply be OR-ed in
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         filled[l] = (count[l] != '0);
         done[l]   = mac_en_i[l] && !lane_abort_i[l] && (cnt[l] == LAST_BIT);
         word[l]   = sr[l] | {result_i[l], {(ACC_WIDTH-1){1'b0}}};
      end
   end

   always_comb begin
      idx   = 0;
      found = 1'b0;
      grant = held_lane;
      if (!held) begin
         grant = rr;
         for (int i = 0; i < NUM_LANES; i++) begin
            idx = int'(rr) + i;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!found && filled[LW'(idx)]) begin
               grant = LW'(idx);
               found = 1'b1;
            end
         end
      end
      out_valid = filled[grant];
      out_lane  = out_valid ? grant : '0;
      out_data  = out_valid ? mem[grant][rp[grant]] : '0;
      handshake = out_valid && out_ready;
   end

   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         pop[l]    = handshake && (grant == LW'(l));
         accept[l] = done[l] && ((count[l] != FULL_CNT) || pop[l]);
         drop[l]   = done[l] && !accept[l];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            sr[l]    <= '0;
            cnt[l]   <= '0;
            wp[l]    <= '0;
            rp[l]    <= '0;
            count[l] <= '0;
         end
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_abort_i[l] || done[l]) begin
               sr[l]  <= '0;
               cnt[l] <= '0;
            end else if (mac_en_i[l]) begin
               sr[l][cnt[l]] <= result_i[l];
               cnt[l]        <= cnt[l] + 1'b1;
            end
            if (accept[l]) wp[l] <= wp[l] + 1'b1;
            if (pop[l]) rp[l] <= rp[l] + 1'b1;
            if (accept[l] && !pop[l]) count[l] <= count[l] + 1'b1;
            else if (!accept[l] && pop[l]) count[l] <= count[l] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < NUM_LANES; l++) begin
         if (accept[l]) mem[l][wp[l]] <= word[l];
      end
   end

   // a drop on the same edge as a clear keeps its bit set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) overflow <= '0;
      else overflow <= (clear_overflow ? '0 : overflow) | drop;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr        <= '0;
         held      <= 1'b0;
         held_lane <= '0;
      end else begin
         held      <= out_valid && !out_ready;
         held_lane <= grant;
         if (handshake) rr <= (grant == LAST_LANE) ? '0 : grant + 1'b1;
      end
   end

endmodule

// File: tb/tb_mx_result_deserializer.sv
// Randomized and directed bench for mx_result_deserializer against a
// queue-based reference model of lanes, FIFOs and the round-robin port.
module tb_mx_result_deserializer;
   localparam int N = 4;
   localparam int W = 32;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] result_i;
   logic [N-1:0] mac_en_i;
   logic [N-1:0] lane_abort_i;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   out_lane;
   logic [N-1:0] overflow;
   logic         clear_overflow;

   always #5 clk = ~clk;

   mx_result_deserializer #(
      .NUM_LANES(N), .ACC_WIDTH(W), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk),
      .reset(reset),
      .result_i(result_i),
      .mac_en_i(mac_en_i),
      .lane_abort_i(lane_abort_i),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_lane(out_lane),
      .overflow(overflow),
      .clear_overflow(clear_overflow)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model
   bit           m_bits [N][$];
   logic [W-1:0] m_fifo [N][$];
   int           m_rr;
   bit           m_locked;
   int           m_lock_lane;
   logic [N-1:0] m_ovf;

   function automatic void model_reset();
      for (int l = 0; l < N; l++) begin
         m_bits[l].delete();
         m_fifo[l].delete();
      end
      m_rr = 0;
      m_locked = 0;
      m_lock_lane = 0;
      m_ovf = '0;
   endfunction

   function automatic int m_grant();
      if (m_locked) return m_lock_lane;
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m_rr + i) % N;
         if (m_fifo[k].size() != 0) return k;
      end
      return -1;
   endfunction

   function automatic void model_step(input logic [N-1:0] res, en, ab,
                                      input logic rdy, clr, input int g);
      logic [N-1:0] drop;
      logic [W-1:0] w;
      drop = '0;
      if (g >= 0 && rdy) begin
         void'(m_fifo[g].pop_front());
         m_rr = (g + 1) % N;
      end
      m_locked = (g >= 0) && !rdy;
      m_lock_lane = g;
      for (int l = 0; l < N; l++) begin
         if (ab[l]) m_bits[l].delete();
         else if (en[l]) begin
            m_bits[l].push_back(res[l]);
            if (m_bits[l].size() == W) begin
               for (int i = 0; i < W; i++) w[i] = m_bits[l][i];
               m_bits[l].delete();
               if (m_fifo[l].size() < D) m_fifo[l].push_back(w);
               else drop[l] = 1'b1;
            end
         end
      end
      m_ovf = (clr ? '0 : m_ovf) | drop;
   endfunction

   typedef struct {
      int           lane;
      logic [W-1:0] data;
      int           cyc;
   } hs_t;
   hs_t got_q[$];
   int  cyc = 0;

   task automatic cycle(input logic [N-1:0] res, en, ab,
                        input logic rdy, clr);
      int g;
      bit ev;
      logic [W-1:0] ed;
      int el;
      hs_t h;
      @(negedge clk);
      cyc++;
      g  = m_grant();
      ev = (g >= 0);
      ed = '0;
      el = 0;
      if (ev) begin
         ed = m_fifo[g][0];
         el = g;
      end
      check("valid", out_valid, ev);
      check("data", out_data, ed);
      check("lane", out_lane, el);
      check("ovf", overflow, m_ovf);
      result_i = res;
      mac_en_i = en;
      lane_abort_i = ab;
      out_ready = rdy;
      clear_overflow = clr;
      if (out_valid && rdy) begin
         h.lane = int'(out_lane);
         h.data = out_data;
         h.cyc  = cyc;
         got_q.push_back(h);
      end
      model_step(res, en, ab, rdy, clr, g);
   endtask

   // serial transmit side
   logic [W-1:0] txq [N][$];
   int           txb [N];
   int           gap_left [N];
   bit           gap8;
   int           en_pct;
   int           rdy_mode;
   logic [N-1:0] abort_next;
   logic         clr_next;

   task automatic run(input int cycles);
      logic [N-1:0] res, en;
      logic rdy;
      logic [W-1:0] cur;
      repeat (cycles) begin
         res = N'($urandom);
         en = '0;
         for (int l = 0; l < N; l++) begin
            if (gap_left[l] > 0) gap_left[l]--;
            else if (txq[l].size() != 0 && $urandom_range(99) < en_pct) begin
               cur = txq[l][0];
               en[l] = 1'b1;
               res[l] = cur[txb[l]];
               if (gap8 && (txb[l] % 8 == 7)) gap_left[l] = 3;
               txb[l]++;
               if (txb[l] == W) begin
                  txb[l] = 0;
                  void'(txq[l].pop_front());
               end
            end
         end
         en = en | (abort_next & N'($urandom));
         case (rdy_mode)
            0: rdy = 1'b0;
            1: rdy = 1'b1;
            default: rdy = 1'($urandom_range(1));
         endcase
         cycle(res, en, abort_next, rdy, clr_next);
         abort_next = '0;
         clr_next = 1'b0;
      end
   endtask

   task automatic clear_tx();
      for (int l = 0; l < N; l++) begin
         txq[l].delete();
         txb[l] = 0;
         gap_left[l] = 0;
      end
   endtask

   task automatic idle_inputs();
      result_i = '0;
      mac_en_i = '0;
      lane_abort_i = '0;
      out_ready = 1'b0;
      clear_overflow = 1'b0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      model_reset();
      clear_tx();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_hs(input string tag, input int k, input int lane,
                           input logic [W-1:0] data);
      if (got_q.size() > k) begin
         check({tag, "_lane"}, got_q[k].lane, lane);
         check({tag, "_data"}, got_q[k].data, data);
      end else begin
         check({tag, "_missing"}, got_q.size(), k + 1);
      end
   endtask

   task automatic check_b2b(input string tag, input int k);
      if (got_q.size() > k) check(tag, got_q[k].cyc - got_q[k-1].cyc, 1);
      else check({tag, "_missing"}, got_q.size(), k + 1);
   endtask

   logic [W-1:0] wb [5];
   logic [W-1:0] rw;

   initial begin
      reset = 1'b0;
      idle_inputs();
      en_pct = 100;
      rdy_mode = 0;
      gap8 = 0;
      abort_next = '0;
      clr_next = 1'b0;
      clear_tx();
      model_reset();
      #1 reset = 1'b1;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_lane", out_lane, 0);
      check("rst_ovf", overflow, 0);
      @(negedge clk);
      reset = 1'b0;

      // single lane, continuous enable
      got_q.delete();
      txq[0].push_back(32'hFFFFFFD8);
      run(31);
      @(posedge clk);
      #1 check("t1_early", out_valid, 0);
      run(1);
      @(posedge clk);
      #1;
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, 32'hFFFFFFD8);
      check("t1_lane", out_lane, 0);
      rdy_mode = 1;
      run(3);
      check("t1_count", got_q.size(), 1);
      check_hs("t1", 0, 0, 32'hFFFFFFD8);

      // gapped bits on lane 2
      got_q.delete();
      gap8 = 1;
      txq[2].push_back(32'h00000007);
      run(48);
      gap8 = 0;
      check("t2_count", got_q.size(), 1);
      check_hs("t2", 0, 2, 32'h00000007);

      // round robin from a fresh pointer
      reset_dut();
      got_q.delete();
      rdy_mode = 1;
      txq[0].push_back(32'h11);
      txq[1].push_back(32'h22);
      txq[2].push_back(32'h33);
      txq[3].push_back(32'h44);
      run(40);
      check("t3_count", got_q.size(), 4);
      check_hs("t3_0", 0, 0, 32'h11);
      check_hs("t3_1", 1, 1, 32'h22);
      check_hs("t3_2", 2, 2, 32'h33);
      check_hs("t3_3", 3, 3, 32'h44);
      check_b2b("t3_b2b1", 1);
      check_b2b("t3_b2b3", 3);
      got_q.delete();
      txq[1].push_back(32'h55);
      txq[3].push_back(32'h77);
      run(40);
      check("t3b_count", got_q.size(), 2);
      check_hs("t3b_0", 0, 1, 32'h55);
      check_hs("t3b_1", 1, 3, 32'h77);
      check_b2b("t3b_b2b", 1);

      // backpressure and overflow on lane 1
      got_q.delete();
      rdy_mode = 0;
      for (int i = 0; i < 5; i++) begin
         wb[i] = $urandom;
         txq[1].push_back(wb[i]);
      end
      run(160);
      @(posedge clk);
      #1;
      check("t4_ovf", overflow[1], 1);
      check("t4_hold_data", out_data, wb[0]);
      check("t4_hold_lane", out_lane, 1);
      rdy_mode = 1;
      run(8);
      check("t4_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) check_hs("t4", i, 1, wb[i]);
      clr_next = 1'b1;
      run(1);
      @(posedge clk);
      #1 check("t4_clear", overflow, 0);

      // full FIFO with a pop on the completing edge
      got_q.delete();
      rdy_mode = 0;
      for (int i = 0; i < 5; i++) begin
         wb[i] = $urandom;
         txq[0].push_back(wb[i]);
      end
      run(159);
      rdy_mode = 1;
      run(1);
      @(posedge clk);
      #1 check("t5_no_ovf", overflow, 0);
      run(10);
      check("t5_count", got_q.size(), 5);
      for (int i = 0; i < 5; i++) check_hs("t5", i, 0, wb[i]);

      // abort a partial word on lane 3
      got_q.delete();
      txq[3].push_back($urandom);
      run(10);
      txq[3].delete();
      txb[3] = 0;
      abort_next = 4'b1000;
      run(1);
      txq[3].push_back(32'h0000ABCD);
      run(40);
      check("t6_count", got_q.size(), 1);
      check_hs("t6", 0, 3, 32'h0000ABCD);

      // asynchronous reset with two words buffered and one partial
      got_q.delete();
      rdy_mode = 0;
      for (int i = 0; i < 3; i++) txq[0].push_back($urandom);
      run(74);
      #2 reset = 1'b1;
      #1;
      check("t7_valid", out_valid, 0);
      check("t7_data", out_data, 0);
      check("t7_lane", out_lane, 0);
      check("t7_ovf", overflow, 0);
      idle_inputs();
      model_reset();
      clear_tx();
      @(negedge clk);
      reset = 1'b0;
      got_q.delete();
      rdy_mode = 1;
      txq[0].push_back(32'h12345678);
      run(40);
      check("t7_count", got_q.size(), 1);
      check_hs("t7", 0, 0, 32'h12345678);

      // random traffic with stalls, gaps, aborts and clears
      en_pct = 75;
      for (int k = 0; k < 1500; k++) begin
         rdy_mode = ((k / 100) % 3 == 1) ? 0 : 2;
         for (int l = 0; l < N; l++) begin
            if (txq[l].size() == 0 && $urandom_range(3) == 0) begin
               rw = $urandom;
               txq[l].push_back(rw);
            end
         end
         if ($urandom_range(49) == 0) abort_next[$urandom_range(N-1)] = 1'b1;
         if ($urandom_range(99) == 0) clr_next = 1'b1;
         run(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mx_result_deserializer.md
# mx_result_deserializer

Receive-side collector for the bit-serial MAC array. Each lane takes the LSB-first 32-bit `result` stream and its `mac_en_o` qualifier from one `j_MX_cell` column and assembles parallel words. Each lane buffers completed words in a small FIFO. A round-robin arbiter presents the buffered words on a single valid/ready port to the downstream writeback logic.

## Interface
- `NUM_LANES`, default 4: number of MAC lanes (columns); must be ≥ 2.
- `ACC_WIDTH`, default 32: bits per serial result word.
- `FIFO_DEPTH`, default 4: words buffered per lane; power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `result_i`  in  NUM_LANES  serial result bit per lane, LSB first.
- `mac_en_i`  in  NUM_LANES  per-lane bit qualifier (connected to cell `mac_en_o`).
- `lane_abort_i`  in  NUM_LANES  synchronous per-lane discard of a partial word.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  ACC_WIDTH  assembled word (two's complement, as produced by the cell).
- `out_lane`  out  $clog2(NUM_LANES)  source lane of `out_data`.
- `overflow`  out  NUM_LANES  sticky: a completed word was dropped.
- `clear_overflow`  in  1  synchronous clear of all `overflow` bits.

## Operation
- Per-lane assembler: a shift register `sr[ACC_WIDTH-1:0]` and a bit counter `cnt` in the range 0..ACC_WIDTH-1.
- Bit capture: on an edge where `mac_en_i[l]`=1, store `result_i[l]` at bit `cnt` and increment `cnt`.
- Gaps: cycles with `mac_en_i[l]`=0 hold `sr` and `cnt`. Gaps of any length are legal mid-word.
- Word completion: capturing with `cnt`=ACC_WIDTH-1 completes the word. The full word (including that edge's bit) is pushed into the lane FIFO on the same edge, and `cnt` wraps to 0.
- Back-to-back words: bit 0 of the next word may arrive on the following edge with no idle cycle.
- `lane_abort_i[l]`=1 forces `cnt`←0 and discards the partial word. It has priority over a capture on the same edge, including the completing capture (no push occurs).
- Lane FIFO: circular buffer of FIFO_DEPTH words with read and write pointers plus a count.
  - Push while full with no pop on that edge: drop the word and set `overflow[l]`.
  - Push and pop on the same edge while full: legal, no drop.
- `overflow` priority: `clear_overflow` clears all bits; a drop on the same edge wins (that bit stays set).
- Arbiter: round-robin pointer `rr`, reset to 0.
  - When no grant is locked, grant the first non-empty lane at or after `rr` (wrapping).
  - The grant is locked while `out_valid && !out_ready`.
  - On handshake (`out_valid && out_ready`): pop the granted FIFO and set `rr` ← granted lane + 1 (mod NUM_LANES).
- Output: `out_valid` = 1 iff the granted FIFO is non-empty.
  - `out_data` and `out_lane` come from the granted FIFO head and the grant index.
  - When `out_valid`=0, both are driven 0.
- Stability: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_lane` are stable, regardless of pushes to other lanes.
- No arithmetic is performed; words pass through bit-exact.

## Timing
- Reset values (asynchronous assert): all `cnt`=0, `sr`=0, FIFOs empty, `rr`=0, no grant locked, `out_valid`=0, `out_data`=0, `out_lane`=0, `overflow`=0.
- Latency: word completes at edge N → `out_valid` may be high from just after edge N, if the FIFO was empty and the lane is granted. That is 1 cycle from the last bit to availability.
- Throughput: one word per cycle at the output; each lane supplies one word per ACC_WIDTH cycles.
- `out_valid` deasserts only after a handshake with the last buffered word, or on reset.
- Reset mid-word: any partial word is lost and buffered words are discarded; the next `mac_en_i` edge after reset release is bit 0.
- `out_ready` may be high while `out_valid`=0; this has no effect.

## Test plan
- Single lane: serialize 0xFFFFFFD8 (−40 = 3·(−10)+(−10)) on lane 0 with `mac_en_i[0]` continuously high → `out_valid` rises the cycle after bit 31, with `out_data`=0xFFFFFFD8 and `out_lane`=0.
- Gapped bits: lane 2 sends 0x00000007 with a 3-cycle `mac_en_i` gap after every 8th bit → the same word arrives intact; `cnt` holds during the gaps.
- Round-robin: all 4 lanes complete words 0x11, 0x22, 0x33, 0x44 on the same edge, with `out_ready`=1 → outputs in lane order 0, 1, 2, 3 on consecutive cycles. Then lanes 1 and 3 complete together → lane 3 is not starved: order 1, 3.
- Backpressure and overflow: `out_ready`=0, lane 1 completes 5 words (FIFO_DEPTH=4) → `overflow[1]`=1, and the first word is held stable on the output. Release `out_ready` → exactly 4 words in order. Pulse `clear_overflow` → `overflow`=0.
- Full with simultaneous pop: lane 0 FIFO full and `out_ready`=1 on the edge a 5th word completes → no overflow; all 5 words are delivered.
- Abort and reset: assert `lane_abort_i[3]` after 10 bits, then send 0x0000ABCD → only 0x0000ABCD is output. Assert `reset` mid-word and with 2 words buffered → all outputs return to reset values immediately.
